mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single RAM port between instruction fetch and data load/store.
// - Serialises the accesses and drives the core stall.
// - Does the func3 byte-lane handling: store shift/byte enables, load extract/extend.
// - Traps misaligned or illegal accesses and memory timeouts.
// - Sits between pc/reg_file/decoder and the RAM; replaces ad-hoc sequencing in ram_controller.
// PARAMETERS
// - TIMEOUT       16  max cycles in WAIT for mem_rvalid before a trap completion
// - MAX_D_GRANTS   4  consecutive data grants allowed while fetch waits; then fetch wins
// PORTS
// - clk           in   1   single clock, all logic on posedge
// - rst           in   1   synchronous, active-high reset
// - if_req_valid  in   1   fetch request; held until if_rsp_valid
// - if_req_addr   in   32  fetch address (program_counter)
// - if_rsp_valid  out  1   one-cycle completion pulse for fetch
// - if_rsp_data   out  32  instruction word; valid with if_rsp_valid
// - if_trap       out  1   fetch fault (misaligned or timeout); valid with if_rsp_valid
// - d_req_valid   in   1   data request; held until d_rsp_valid
// - d_req_we      in   1   1 = store, 0 = load
// - d_req_func3   in   3   RV32I width/sign code
// - d_req_addr    in   32  byte address
// - d_req_wdata   in   32  store data (rs2), unshifted
// - d_rsp_valid   out  1   one-cycle completion pulse for data
// - d_rsp_rdata   out  32  load result, extended; 0 for stores
// - d_trap        out  1   data fault; valid with d_rsp_valid
// - stall         out  1   (if_req_valid & ~if_rsp_valid) | (d_req_valid & ~d_rsp_valid)
// - mem_req       out  1   one-cycle RAM command strobe
// - mem_we        out  1   write command
// - mem_addr      out  32  word address; bits [1:0] = 0
// - mem_be        out  4   byte enables; 4'hF on reads
// - mem_wdata     out  32  lane-shifted store data
// - mem_rvalid    in   1   RAM completion for reads and writes
// - mem_rdata     in   32  RAM read word
// BEHAVIOUR
// - Reset: state=IDLE, grant counter 0, timeout counter 0, all outputs 0 except stall (combinational).
// - The RAM is reset by the same rst, so no stale mem_rvalid arrives after reset.
// - FSM IDLE->ISSUE->WAIT->RESP->IDLE. Owner register {FETCH, DATA} is latched in IDLE.
// - IDLE, grant when any valid:
//   - d only: grant DATA.
//   - i only: grant FETCH.
//   - both: grant DATA unless the grant counter equals MAX_D_GRANTS, then FETCH.
// - Grant counter: +1 on a DATA grant while if_req_valid; cleared on a FETCH grant; saturates.
// - IDLE with a DATA grant that is misaligned or illegal: go straight to RESP with d_trap=1; no mem_req.
//   - LH/LHU/SH with addr[0]; LW/SW with addr[1:0] != 0.
//   - Load func3 in {3,6,7}; store func3 >= 3.
// - IDLE with a FETCH grant and if_req_addr[1:0] != 0: go straight to RESP with if_trap=1; no mem_req.
// - ISSUE: mem_req=1 for exactly one cycle with registered we/addr/be/wdata; then go to WAIT.
// - WAIT: count cycles.
//   - mem_rvalid: latch the data and go to RESP.
//   - Count reaches TIMEOUT: go to RESP with the owner's trap=1 and data 0.
//   - A late mem_rvalid after a timeout is ignored.
// - RESP: the owner's rsp_valid=1 for one cycle; then IDLE. Requests are not sampled in RESP, so no double-serve.
// - Minimum latency: request at cycle 0 -> mem_req at 1 -> mem_rvalid at 2 -> rsp_valid at 3.
// - Store lanes, with sh = addr[1:0]*8:
//   - SB: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
//   - SH: be = 3<<addr[1:0], wdata = {2{wdata[15:0]}}.
//   - SW: be = F, wdata unchanged.
// - Load: word = mem_rdata >> sh.
//   - LB/LH sign-extend [7:0]/[15:0]; LBU/LHU zero-extend; LW passes through.
// - Reset during ISSUE/WAIT/RESP: return to IDLE next edge; no rsp_valid, trap or mem_req follows.
// STRUCTURE
// - mem_arb_pkg:
//   - arb_state_e {IDLE, ISSUE, WAIT, RESP}
//   - owner_e {FETCH, DATA}
//   - F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW localparams
// - Sub-module lsu_align (combinational): func3+addr+wdata -> be, wdata, illegal, misaligned; rdata -> extended load.
// - The top holds the FSM, owner, grant counter, timeout counter and response registers.
// TESTING
// - Fetch only, addr 0x100, RAM returns 0x00500093 after 1 cycle -> mem_req at cycle 1, be=F, if_rsp_valid at cycle 3 with data 0x00500093.
// - Both valid, 6 back-to-back data requests while fetch waits -> DATA served 4 times, then FETCH, then DATA.
// - LB addr 0x203, rdata 0x80FF_FF7F -> d_rsp_rdata 0xFFFF_FF80; LHU addr 0x202 -> 0x0000_80FF.
// - SH addr 0x206, wdata 0x1234_ABCD -> mem_addr 0x204, be 4'b1100, mem_wdata 0xABCD_ABCD.
// - LW addr 0x201 -> d_trap=1, no mem_req. mem_rvalid never arrives -> trap at TIMEOUT+3 cycles.
// - rst asserted in WAIT -> IDLE next cycle, no rsp pulse, outputs 0; a new fetch then completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned DEF_TIMEOUT      = 16;
   localparam int unsigned DEF_MAX_D_GRANTS = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
   typedef enum logic {FETCH, DATA} owner_e;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // One registered RAM command.
   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [3:0]      be;
      logic [XLEN-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and RAM signals of the arbiter; slave = arbiter side, master = core/RAM side.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic            if_req_valid;
   logic [XLEN-1:0] if_req_addr;
   logic            if_rsp_valid;
   logic [XLEN-1:0] if_rsp_data;
   logic            if_trap;
   logic            d_req_valid;
   logic            d_req_we;
   logic [2:0]      d_req_func3;
   logic [XLEN-1:0] d_req_addr;
   logic [XLEN-1:0] d_req_wdata;
   logic            d_rsp_valid;
   logic [XLEN-1:0] d_rsp_rdata;
   logic            d_trap;
   logic            stall;
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [3:0]      mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_func3,
             d_req_addr, d_req_wdata, mem_rvalid, mem_rdata,
      output if_rsp_valid, if_rsp_data, if_trap, d_rsp_valid, d_rsp_rdata,
             d_trap, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_func3,
             d_req_addr, d_req_wdata, mem_rvalid, mem_rdata,
      input  if_rsp_valid, if_rsp_data, if_trap, d_rsp_valid, d_rsp_rdata,
             d_trap, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane handling: store shift/enables and legality from func3/addr, load extract/extend.
module lsu_align
   import mem_arb_pkg::*;
(
   input  logic            we,
   input  logic [2:0]      func3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_sh,
   output logic            illegal,
   output logic            misaligned,
   input  logic [2:0]      ld_func3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] rdata_ext
);

   logic [XLEN-1:0] word;

   // Store lanes: narrow data is replicated so the byte enables pick the lane.
   always_comb begin
      be       = 4'hF;
      wdata_sh = wdata;
      case (func3)
         F3_SB: begin
            be       = 4'(4'b0001 << addr_lo);
            wdata_sh = {4{wdata[7:0]}};
         end
         F3_SH: begin
            be       = 4'(4'b0011 << addr_lo);
            wdata_sh = {2{wdata[15:0]}};
         end
         default: ;
      endcase
      illegal    = we ? (func3 > F3_SW) : ((func3 == 3'd3) || (func3 > F3_LHU));
      misaligned = (((func3 == F3_LH) || (func3 == F3_LHU)) && addr_lo[0]) ||
                   ((func3 == F3_LW) && (addr_lo != 2'b00));
   end

   always_comb begin
      word = rdata >> {ld_addr_lo, 3'b000};
      case (ld_func3)
         F3_LB:   rdata_ext = {{24{word[7]}}, word[7:0]};
         F3_LH:   rdata_ext = {{16{word[15]}}, word[15:0]};
         F3_LBU:  rdata_ext = {24'h0, word[7:0]};
         F3_LHU:  rdata_ext = {16'h0, word[15:0]};
         default: rdata_ext = word;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data load/store onto one RAM port, with traps and core stall.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
   parameter int unsigned MAX_D_GRANTS = DEF_MAX_D_GRANTS
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned GNT_W = $clog2(MAX_D_GRANTS + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
   localparam logic [GNT_W-1:0] GNT_MAX = GNT_W'(MAX_D_GRANTS);

   arb_state_e      state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [GNT_W-1:0] gnt_q, gnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   mem_cmd_t        cmd_q, cmd_d;
   logic            req_q, req_d;
   logic            st_q, st_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lo_q, lo_d;
   logic            i_vld_q, i_vld_d, i_trap_q, i_trap_d;
   logic            d_vld_q, d_vld_d, d_trap_q, d_trap_d;
   logic [XLEN-1:0] i_data_q, i_data_d, d_data_q, d_data_d;

   logic [3:0]      be_c;
   logic [XLEN-1:0] wdata_c, ld_ext_c;
   logic            illegal_c, misaligned_c, d_win_c;

   lsu_align u_lsu_align (
      .we         (bus.d_req_we),
      .func3      (bus.d_req_func3),
      .addr_lo    (bus.d_req_addr[1:0]),
      .wdata      (bus.d_req_wdata),
      .be         (be_c),
      .wdata_sh   (wdata_c),
      .illegal    (illegal_c),
      .misaligned (misaligned_c),
      .ld_func3   (f3_q),
      .ld_addr_lo (lo_q),
      .rdata      (bus.mem_rdata),
      .rdata_ext  (ld_ext_c)
   );

   // Data wins unless fetch has already waited through MAX_D_GRANTS data grants.
   assign d_win_c = bus.d_req_valid && (!bus.if_req_valid || (gnt_q != GNT_MAX));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      gnt_d    = gnt_q;
      tmo_d    = tmo_q;
      cmd_d    = cmd_q;
      req_d    = 1'b0;
      st_d     = st_q;
      f3_d     = f3_q;
      lo_d     = lo_q;
      i_vld_d  = 1'b0;
      i_trap_d = 1'b0;
      i_data_d = i_data_q;
      d_vld_d  = 1'b0;
      d_trap_d = 1'b0;
      d_data_d = d_data_q;
      unique case (state_q)
         IDLE: begin
            if (d_win_c) begin
               owner_d = DATA;
               if (bus.if_req_valid && (gnt_q != GNT_MAX)) gnt_d = gnt_q + GNT_W'(1);
               st_d = bus.d_req_we;
               f3_d = bus.d_req_func3;
               lo_d = bus.d_req_addr[1:0];
               if (illegal_c || misaligned_c) begin
                  state_d  = RESP;
                  d_vld_d  = 1'b1;
                  d_trap_d = 1'b1;
                  d_data_d = '0;
               end else begin
                  state_d     = ISSUE;
                  req_d       = 1'b1;
                  cmd_d.we    = bus.d_req_we;
                  cmd_d.addr  = {bus.d_req_addr[XLEN-1:2], 2'b00};
                  cmd_d.be    = bus.d_req_we ? be_c : 4'hF;
                  cmd_d.wdata = bus.d_req_we ? wdata_c : '0;
               end
            end else if (bus.if_req_valid) begin
               owner_d = FETCH;
               gnt_d   = '0;
               if (bus.if_req_addr[1:0] != 2'b00) begin
                  state_d  = RESP;
                  i_vld_d  = 1'b1;
                  i_trap_d = 1'b1;
                  i_data_d = '0;
               end else begin
                  state_d     = ISSUE;
                  req_d       = 1'b1;
                  cmd_d.we    = 1'b0;
                  cmd_d.addr  = {bus.if_req_addr[XLEN-1:2], 2'b00};
                  cmd_d.be    = 4'hF;
                  cmd_d.wdata = '0;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            tmo_d   = '0;
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               state_d = RESP;
               if (owner_q == FETCH) begin
                  i_vld_d  = 1'b1;
                  i_data_d = bus.mem_rdata;
               end else begin
                  d_vld_d  = 1'b1;
                  d_data_d = st_q ? '0 : ld_ext_c;
               end
            end else if (tmo_q == TMO_MAX) begin
               state_d = RESP;
               if (owner_q == FETCH) begin
                  i_vld_d  = 1'b1;
                  i_trap_d = 1'b1;
                  i_data_d = '0;
               end else begin
                  d_vld_d  = 1'b1;
                  d_trap_d = 1'b1;
                  d_data_d = '0;
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= FETCH;
         gnt_q    <= '0;
         tmo_q    <= '0;
         cmd_q    <= '0;
         req_q    <= 1'b0;
         st_q     <= 1'b0;
         f3_q     <= '0;
         lo_q     <= '0;
         i_vld_q  <= 1'b0;
         i_trap_q <= 1'b0;
         i_data_q <= '0;
         d_vld_q  <= 1'b0;
         d_trap_q <= 1'b0;
         d_data_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         tmo_q    <= tmo_d;
         cmd_q    <= cmd_d;
         req_q    <= req_d;
         st_q     <= st_d;
         f3_q     <= f3_d;
         lo_q     <= lo_d;
         i_vld_q  <= i_vld_d;
         i_trap_q <= i_trap_d;
         i_data_q <= i_data_d;
         d_vld_q  <= d_vld_d;
         d_trap_q <= d_trap_d;
         d_data_q <= d_data_d;
      end
   end

   assign bus.if_rsp_valid = i_vld_q;
   assign bus.if_rsp_data  = i_data_q;
   assign bus.if_trap      = i_trap_q;
   assign bus.d_rsp_valid  = d_vld_q;
   assign bus.d_rsp_rdata  = d_data_q;
   assign bus.d_trap       = d_trap_q;
   assign bus.mem_req      = req_q;
   assign bus.mem_we       = cmd_q.we;
   assign bus.mem_addr     = cmd_q.addr;
   assign bus.mem_be       = cmd_q.be;
   assign bus.mem_wdata    = cmd_q.wdata;
   assign bus.stall        = (bus.if_req_valid && !i_vld_q) || (bus.d_req_valid && !d_vld_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: RAM model plus a transaction-level reference of memory contents.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;

   logic [31:0] ram     [256];
   logic [31:0] ref_mem [256];
   bit          drop_next;
   bit          rand_lat;
   int          n_memreq;
   logic [31:0] cur_if_addr;
   logic        cur_d_we;
   logic [2:0]  cur_d_f3;
   logic [31:0] cur_d_addr, cur_d_wdata;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic [7:0]  order_q[$];

   mem_arbiter_if bus();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference rules written from the access size: 1, 2 or 4 bytes.
   function automatic int unsigned acc_size(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic logic is_trap(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return !legal || ((addr % acc_size(f3)) != 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      int unsigned sz;
      logic [31:0] v, mask;
      sz = acc_size(f3);
      v  = word >> (8 * addr[1:0]);
      if (sz < 4) begin
         mask = (32'd1 << (8 * sz)) - 32'd1;
         v    = v & mask;
         if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      return 4'(((32'd1 << acc_size(f3)) - 32'd1) << addr[1:0]);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] v;
      int unsigned sz;
      sz = acc_size(f3);
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % sz) +: 8];
      return v;
   endfunction

   task automatic store_apply(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int unsigned b;
      for (int i = 0; i < int'(acc_size(f3)); i++) begin
         b = addr[1:0] + i;
         ref_mem[addr[9:2]][8*b +: 8] = wd[8*i +: 8];
      end
   endtask

   // RAM: command seen on a negedge, completion driven just after a later posedge.
   initial begin
      int          cnt, lat, idx;
      logic [31:0] rd;
      logic        nv;
      cnt = 0;
      rd  = '0;
      forever begin
         @(negedge clk);
         nv = 1'b0;
         if (rst) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) nv = 1'b1;
            end
            if (bus.mem_req === 1'b1) begin
               if (drop_next) drop_next = 1'b0;
               else begin
                  idx = int'(bus.mem_addr[9:2]);
                  if (bus.mem_we)
                     for (int i = 0; i < 4; i++)
                        if (bus.mem_be[i]) ram[idx][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                  rd  = ram[idx];
                  lat = rand_lat ? int'($urandom_range(1, 3)) : 1;
                  if (lat == 1) nv = 1'b1;
                  else cnt = lat - 1;
               end
            end
         end
         @(posedge clk);
         #1;
         bus.mem_rvalid = nv;
         bus.mem_rdata  = nv ? rd : $urandom;
      end
   end

   // Command monitor: fetch lives below 0x200, data at 0x200 and above.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) begin
            n_memreq++;
            last_addr  = bus.mem_addr;
            last_be    = bus.mem_be;
            last_wdata = bus.mem_wdata;
            if (bus.mem_addr < 32'h200) begin
               order_q.push_back(8'h46);
               chk("mreq_f_addr", bus.mem_addr, cur_if_addr & ~32'd3);
               chk("mreq_f_we_be", 32'({bus.mem_we, bus.mem_be}), 32'h0F);
            end else begin
               order_q.push_back(8'h44);
               chk("mreq_d_addr", bus.mem_addr, cur_d_addr & ~32'd3);
               chk("mreq_d_we", 32'(bus.mem_we), 32'(cur_d_we));
               chk("mreq_d_be", 32'(bus.mem_be), cur_d_we ? 32'(exp_be(cur_d_f3, cur_d_addr)) : 32'hF);
               if (cur_d_we) chk("mreq_d_wdata", bus.mem_wdata, exp_wdata(cur_d_f3, cur_d_wdata));
            end
         end
      end
   end

   task automatic do_fetch(input logic [31:0] a, input int exp_lat, output logic [31:0] got);
      int c0, guard;
      cur_if_addr      = a;
      bus.if_req_addr  = a;
      bus.if_req_valid = 1'b1;
      c0 = cyc;
      @(negedge clk);
      chk("if_stall", 32'(bus.stall), 32'd1);
      guard = 0;
      while (bus.if_rsp_valid !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      got = bus.if_rsp_data;
      if (guard >= 200) chk("if_rsp_seen", 32'(bus.if_rsp_valid), 32'd1);
      else begin
         if (exp_lat >= 0) chk("if_lat", 32'(cyc - c0), 32'(exp_lat));
         if (a[1:0] != 2'b00) chk("if_trap_mis", 32'(bus.if_trap), 32'd1);
         else begin
            chk("if_trap", 32'(bus.if_trap), 32'd0);
            chk("if_data", got, ref_mem[a[9:2]]);
         end
      end
      @(posedge clk);
      #1;
      bus.if_req_valid = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat, input logic exp_tmo,
                          output logic [31:0] got);
      int   c0, guard;
      logic trap_e;
      cur_d_we        = we;
      cur_d_f3        = f3;
      cur_d_addr      = addr;
      cur_d_wdata     = wd;
      bus.d_req_we    = we;
      bus.d_req_func3 = f3;
      bus.d_req_addr  = addr;
      bus.d_req_wdata = wd;
      bus.d_req_valid = 1'b1;
      c0 = cyc;
      @(negedge clk);
      chk("d_stall", 32'(bus.stall), 32'd1);
      guard = 0;
      while (bus.d_rsp_valid !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      got = bus.d_rsp_rdata;
      if (guard >= 200) chk("d_rsp_seen", 32'(bus.d_rsp_valid), 32'd1);
      else begin
         trap_e = exp_tmo || is_trap(we, f3, addr);
         chk("d_trap", 32'(bus.d_trap), 32'(trap_e));
         if (exp_lat >= 0) chk("d_lat", 32'(cyc - c0), 32'(exp_lat));
         if (exp_tmo) chk("d_tmo_data", got, 32'd0);
         else if (!trap_e) begin
            if (we) begin
               chk("d_st_rdata", got, 32'd0);
               store_apply(f3, addr, wd);
            end else begin
               chk("d_ld_rdata", got, exp_load(f3, addr, ref_mem[addr[9:2]]));
            end
         end
      end
      @(posedge clk);
      #1;
      bus.d_req_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] got, a, wd;
      logic [2:0]  f3;
      logic        we;
      logic [7:0]  exp_ord [6];
      int          n0, pulses;

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      n_memreq = 0;
      drop_next = 1'b0;
      rand_lat  = 1'b0;
      rst = 1'b1;
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = '0;
      bus.d_req_valid  = 1'b0;
      bus.d_req_we     = 1'b0;
      bus.d_req_func3  = '0;
      bus.d_req_addr   = '0;
      bus.d_req_wdata  = '0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = '0;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[64]  = 32'h0050_0093;  ref_mem[64]  = ram[64];
      ram[128] = 32'h80FF_FF7F;  ref_mem[128] = ram[128];

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_if_vld", 32'(bus.if_rsp_valid), 32'd0);
      chk("rst_d_vld", 32'(bus.d_rsp_valid), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_traps", 32'({bus.if_trap, bus.d_trap}), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_d_rdata", bus.d_rsp_rdata, 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;

      do_fetch(32'h100, 3, got);
      chk("fetch_word", got, 32'h0050_0093);
      chk("fetch_be", 32'(last_be), 32'hF);

      do_data(1'b0, 3'd0, 32'h203, 32'h0, 3, 1'b0, got);
      chk("lb_value", got, 32'hFFFF_FF80);
      do_data(1'b0, 3'd5, 32'h202, 32'h0, 3, 1'b0, got);
      chk("lhu_value", got, 32'h0000_80FF);

      do_data(1'b1, 3'd1, 32'h206, 32'h1234_ABCD, 3, 1'b0, got);
      chk("sh_mem_addr", last_addr, 32'h204);
      chk("sh_mem_be", 32'(last_be), 32'hC);
      chk("sh_mem_wdata", last_wdata, 32'hABCD_ABCD);
      do_data(1'b0, 3'd2, 32'h204, 32'h0, 3, 1'b0, got);

      n0 = n_memreq;
      do_data(1'b0, 3'd2, 32'h201, 32'h0, 1, 1'b0, got);
      chk("lw_mis_no_req", 32'(n_memreq - n0), 32'd0);
      do_data(1'b1, 3'd3, 32'h208, 32'h5, 1, 1'b0, got);
      do_fetch(32'h102, 1, got);

      drop_next = 1'b1;
      do_data(1'b0, 3'd2, 32'h210, 32'h0, 19, 1'b1, got);

      // Fetch starved by data: four data grants, then fetch, then data again.
      do_fetch(32'h0, -1, got);
      order_q.delete();
      fork
         begin
            logic [31:0] g;
            do_fetch(32'h40, -1, g);
         end
         begin
            logic [31:0] g;
            for (int i = 0; i < 6; i++) do_data(1'b0, 3'd2, 32'h300 + 32'(4 * i), 32'h0, -1, 1'b0, g);
         end
      join
      exp_ord = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46, 8'h44};
      chk("arb_order_len", 32'(order_q.size() >= 6), 32'd1);
      if (order_q.size() >= 6)
         for (int i = 0; i < 6; i++) chk($sformatf("arb_order_%0d", i), 32'(order_q[i]), 32'(exp_ord[i]));

      // Reset while waiting on the RAM.
      cur_if_addr      = 32'h80;
      drop_next        = 1'b1;
      bus.if_req_addr  = 32'h80;
      bus.if_req_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.if_req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n0  = n_memreq;
      @(negedge clk);
      chk("wrst_vld", 32'({bus.if_rsp_valid, bus.d_rsp_valid}), 32'd0);
      chk("wrst_trap", 32'({bus.if_trap, bus.d_trap}), 32'd0);
      chk("wrst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("wrst_stall", 32'(bus.stall), 32'd0);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.if_rsp_valid === 1'b1 || bus.if_trap === 1'b1) pulses++;
      end
      chk("wrst_no_rsp", 32'(pulses), 32'd0);
      chk("wrst_no_req", 32'(n_memreq - n0), 32'd0);
      @(posedge clk);
      #1;
      do_fetch(32'h104, 3, got);

      // Random concurrent traffic with variable RAM latency.
      rand_lat = 1'b1;
      fork
         begin
            logic [31:0] g, fa;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               fa = 32'($urandom_range(0, 63)) << 2;
               if ($urandom_range(0, 9) == 0) fa = fa | 32'($urandom_range(1, 3));
               do_fetch(fa, -1, g);
            end
         end
         begin
            logic [31:0] g;
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               we = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 9) < 8)
                  f3 = we ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 32'd1) % 6);
               else
                  f3 = 3'($urandom_range(0, 7));
               if (!we && f3 == 3'd3) f3 = 3'd4;
               a = 32'h200 + 32'($urandom_range(0, 511));
               if ($urandom_range(0, 9) < 8) a = a & ~(32'(acc_size(f3)) - 32'd1);
               wd = $urandom;
               do_data(we, f3, a, wd, -1, 1'b0, g);
            end
         end
      join

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit got=%0d exp=%0d", cyc, 0);
      $fatal(1, "time limit");
   end

endmodule
